// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 matrix keypad scanner.
package keypad_pkg;

  localparam int unsigned NUM_ROWS = 4;
  localparam int unsigned NUM_COLS = 4;

  typedef logic [3:0] key_code_t;

  // Bit 4 set marks a non-key candidate; low bits carry the key code otherwise.
  typedef logic [4:0] cand_t;
  localparam cand_t CAND_NONE  = 5'h10;
  localparam cand_t CAND_MULTI = 5'h11;

  typedef enum logic {StIdle, StPressed} state_e;

  // Active-low row drive, index 0 in the low nibble.
  localparam logic [15:0] ROW_PATTERN = 16'b0111_1011_1101_1110;

  function automatic logic [3:0] row_drive(input logic [1:0] idx);
    return ROW_PATTERN[{idx, 2'b00} +: 4];
  endfunction

  function automatic cand_t resolve(input logic [NUM_ROWS*NUM_COLS-1:0] snap);
    cand_t       c;
    int unsigned n;
    c = CAND_NONE;
    n = 0;
    for (int i = 0; i < NUM_ROWS * NUM_COLS; i++) begin
      if (snap[i]) begin
        n++;
        c = {1'b0, 4'(i)};
      end
    end
    if (n > 1) c = CAND_MULTI;
    return c;
  endfunction

endpackage

// File: rtl/keypad_row_scan.sv
// Row-period timebase: tick counter, row index, registered row drive and strobes.
module keypad_row_scan
  import keypad_pkg::*;
#(
  parameter int unsigned ROW_TICKS = 50000
) (
  input  logic       clk,
  input  logic       rst,
  output logic [3:0] row,
  output logic [1:0] row_idx,
  output logic       sample,
  output logic       frame_end
);

  localparam int unsigned      TickW    = $clog2(ROW_TICKS);
  localparam logic [TickW-1:0] LastTick = TickW'(ROW_TICKS - 1);

  logic [TickW-1:0] tick_q;
  logic [1:0]       idx_q;
  logic [3:0]       row_q;

  assign sample    = (tick_q == LastTick);
  assign frame_end = sample && (idx_q == 2'd3);
  assign row       = row_q;
  assign row_idx   = idx_q;

  // Row register moves together with the index so drive and index never disagree.
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_q <= '0;
      idx_q  <= 2'd0;
      row_q  <= row_drive(2'd0);
    end else if (sample) begin
      tick_q <= '0;
      idx_q  <= idx_q + 2'd1;
      row_q  <= row_drive(idx_q + 2'd1);
    end else begin
      tick_q <= tick_q + TickW'(1);
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: column sync, frame snapshot, single-key resolve, frame debounce,
// press/release FSM and a valid/ack key handshake with sticky overrun.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned ROW_TICKS       = 50000,
  parameter int unsigned DEBOUNCE_FRAMES = 4
) (
  input  logic       clk,
  input  logic       rst,
  output logic [3:0] row,
  input  logic [3:0] col,
  input  logic       key_ack,
  output key_code_t  key_code,
  output logic       key_valid,
  output logic       key_held,
  output logic       overrun
);

  localparam int unsigned     CntW   = $clog2(DEBOUNCE_FRAMES + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_FRAMES);

  logic [1:0] row_idx;
  logic       sample;
  logic       frame_end;

  keypad_row_scan #(
    .ROW_TICKS(ROW_TICKS)
  ) u_row_scan (
    .clk      (clk),
    .rst      (rst),
    .row      (row),
    .row_idx  (row_idx),
    .sample   (sample),
    .frame_end(frame_end)
  );

  logic [3:0]                   col_meta_q, col_sync_q;
  logic [NUM_ROWS*NUM_COLS-1:0] snap_q, snap_d;
  cand_t                        cand, prev_cand_q, prev_cand_d;
  logic [CntW-1:0]              stable_q, stable_d;
  state_e                       state_q, state_d;
  logic                         press;
  key_code_t                    code_q;
  logic                         valid_q, overrun_q;

  // Row 3 lands in the snapshot on the resolve cycle itself, so resolve from the next value.
  always_comb begin
    snap_d = snap_q;
    if (sample) snap_d[{row_idx, 2'b00} +: NUM_COLS] = ~col_sync_q;
  end

  assign cand = resolve(snap_d);

  always_comb begin
    prev_cand_d = prev_cand_q;
    stable_d    = stable_q;
    state_d     = state_q;
    press       = 1'b0;
    if (frame_end) begin
      if (cand == prev_cand_q) begin
        if (stable_q != CntMax) stable_d = stable_q + CntW'(1);
      end else begin
        stable_d    = CntW'(1);
        prev_cand_d = cand;
      end
      unique case (state_q)
        StIdle: begin
          if (!cand[4] && stable_d == CntMax) begin
            state_d = StPressed;
            press   = 1'b1;
          end
        end
        StPressed: begin
          if (cand == CAND_NONE && stable_d == CntMax) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_meta_q  <= 4'hF;
      col_sync_q  <= 4'hF;
      snap_q      <= '0;
      prev_cand_q <= CAND_NONE;
      stable_q    <= '0;
      state_q     <= StIdle;
    end else begin
      col_meta_q  <= col;
      col_sync_q  <= col_meta_q;
      snap_q      <= snap_d;
      prev_cand_q <= prev_cand_d;
      stable_q    <= stable_d;
      state_q     <= state_d;
    end
  end

  // A new press beats a same-cycle ack; overrun only when an unacked key is overwritten.
  always_ff @(posedge clk) begin
    if (rst) begin
      code_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else if (press) begin
      code_q    <= cand[3:0];
      valid_q   <= 1'b1;
      overrun_q <= valid_q && !key_ack;
    end else if (key_ack && valid_q) begin
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end
  end

  assign key_code  = code_q;
  assign key_valid = valid_q;
  assign overrun   = overrun_q;
  assign key_held  = (state_q == StPressed);

endmodule
